// File: rtl/popcount_sched.sv
// popcount_sched
// ---------------------------------------------------------------------------
// Shares a single 32-bit population-count tree among four requesters.
// A round-robin arbiter grants at most one pending request per cycle. The
// granted word is counted and the result is registered, tagged with the
// requester ID. A saturating running total is also kept per requester.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   req_i        per-requester request, held high until granted
//   data_i       request words, requester i owns [32*i+31 : 32*i]
//   clr_i        per-requester running-total clear (one-cycle pulse)
//   gnt_o        one-hot grant, combinational from req_i and the pointer
//   res_valid_o  one-cycle pulse per accepted request
//   res_id_o     ID of the requester whose count is on res_cnt_o
//   res_cnt_o    ones count of the accepted word, 0..32
//   acc_o        running totals, requester i owns [ACC_W*i+ACC_W-1 : ACC_W*i]
//
// Handshake: a request is accepted on the rising edge where req_i[i] and
// gnt_o[i] are both high (gnt_o acts as the ready). The requester holds
// req_i[i] and its data word stable until that edge. Results have no ready:
// res_* is valid for exactly the cycle res_valid_o is high.
// ---------------------------------------------------------------------------
module popcount_sched #(
  parameter int NREQ  = 4,
  parameter int ACC_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic [32*NREQ-1:0]      data_i,
  input  logic [NREQ-1:0]         clr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    res_valid_o,
  output logic [1:0]              res_id_o,
  output logic [5:0]              res_cnt_o,
  output logic [NREQ*ACC_W-1:0]   acc_o
);

  localparam int SUM_W = ACC_W + 1;

  // Registered state
  logic [1:0]                  ptr_q, ptr_d;
  logic                        res_valid_q, res_valid_d;
  logic [1:0]                  res_id_q, res_id_d;
  logic [5:0]                  res_cnt_q, res_cnt_d;
  logic [NREQ-1:0][ACC_W-1:0]  acc_q, acc_d;

  // Arbitration and datapath
  logic [NREQ-1:0]  gnt;
  logic [1:0]       gid;
  logic [1:0]       idx;
  logic             accept;
  logic [31:0]      word;
  logic [5:0]       cnt;
  logic [ACC_W-1:0] base;
  logic [SUM_W-1:0] sum;

  // Round-robin search starting at ptr_q; the first set request wins.
  always_comb begin
    gnt    = '0;
    gid    = '0;
    idx    = '0;
    accept = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!accept && req_i[idx]) begin
        accept   = 1'b1;
        gid      = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  assign gnt_o = gnt;

  // Single shared count tree fed by the granted word.
  always_comb begin
    word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gid == 2'(i)) word = data_i[32*i +: 32];
    end
    cnt = '0;
    for (int b = 0; b < 32; b++) begin
      cnt = cnt + 6'(word[b]);
    end
  end

  // Next-state. Clear is applied before the add, so clear plus accept on the
  // same channel leaves just the new count. The extra sum bit is the carry
  // out of the add, which flags saturation.
  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_cnt_d   = res_cnt_q;
    acc_d       = acc_q;
    base        = '0;
    sum         = '0;
    for (int i = 0; i < NREQ; i++) begin
      base = clr_i[i] ? '0 : acc_q[i];
      if (accept && (gid == 2'(i))) begin
        sum      = {1'b0, base} + SUM_W'(cnt);
        acc_d[i] = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      end else begin
        acc_d[i] = base;
      end
    end
    if (accept) begin
      ptr_d       = gid + 2'd1;
      res_valid_d = 1'b1;
      res_id_d    = gid;
      res_cnt_d   = cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_cnt_q   <= '0;
      acc_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_cnt_q   <= res_cnt_d;
      acc_q       <= acc_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_cnt_o   = res_cnt_q;
  assign acc_o       = acc_q;

endmodule

// File: tb/tb_popcount_sched.sv
// tb_popcount_sched
// Directed scenarios plus a randomized protocol-respecting run, compared
// against a behavioural model of the scheduler rules.
module tb_popcount_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] data;
  logic [3:0]   clr;
  logic [3:0]   gnt;
  logic         res_valid;
  logic [1:0]   res_id;
  logic [5:0]   res_cnt;
  logic [63:0]  acc;

  popcount_sched #(.NREQ(4), .ACC_W(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .data_i      (data),
    .clr_i       (clr),
    .gnt_o       (gnt),
    .res_valid_o (res_valid),
    .res_id_o    (res_id),
    .res_cnt_o   (res_cnt),
    .acc_o       (acc)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int   m_ptr;
  int   m_acc[4];
  bit   m_rv;
  int   m_rid;
  int   m_rcnt;
  int   m_last_g;
  bit   sb_on = 1'b0;
  logic [7:0] exp_q[$];   // {id, count} of each expected result
  logic [3:0] obs_gnt, exp_gnt;

  task automatic model_reset();
    m_ptr = 0; m_rv = 0; m_rid = 0; m_rcnt = 0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] r);
    logic [3:0] g;
    g = '0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (g == 4'b0 && r[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle, samples the combinational grant, advances one edge and
  // steps the model. Outputs are then stable for the caller to compare.
  task automatic drive_cycle(input logic rst_b, input logic [3:0] r,
                             input logic [127:0] d, input logic [3:0] c);
    int g;
    int cnt;
    rst_n = rst_b; req = r; data = d; clr = c;
    #1;
    obs_gnt = gnt;
    exp_gnt = model_gnt(r);
    @(posedge clk);
    #1;
    m_last_g = -1;
    if (!rst_b) begin
      model_reset();
    end else begin
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && r[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      for (int i = 0; i < 4; i++) if (c[i]) m_acc[i] = 0;
      if (g >= 0) begin
        cnt = $countones(d[32*g +: 32]);
        m_acc[g] = (m_acc[g] + cnt > 65535) ? 65535 : m_acc[g] + cnt;
        m_rv = 1; m_rid = g; m_rcnt = cnt;
        m_ptr = (g + 1) % 4;
        m_last_g = g;
        if (sb_on) exp_q.push_back({2'(g), 6'(cnt)});
      end else begin
        m_rv = 0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; clr = 4'b0000; data = rand_data();
    repeat (3) begin @(posedge clk); #1; end
    model_reset();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", res_id); end
    checks++; if (res_cnt !== 6'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", res_cnt); end
    checks++; if (acc !== 64'd0) begin errors++; $display("FAIL rst_acc got=%h exp=0", acc); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_gnt got=%b exp=0001", gnt); end
    drive_cycle(1'b1, 4'b1111, rand_data(), 4'b0000);
    checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt got=%b exp=0001", obs_gnt); end
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin
      errors++; $display("FAIL rst_first_res got=%b/%0d exp=1/0", res_valid, res_id); end
    checks++; if (res_cnt !== 6'(m_rcnt)) begin errors++; $display("FAIL rst_first_cnt got=%0d exp=%0d", res_cnt, m_rcnt); end
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = rand_data();
    d[95:64] = 32'hF0F0_0001;
    drive_cycle(1'b1, 4'b0100, d, 4'b0000);
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", obs_gnt); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", res_id); end
    checks++; if (res_cnt !== 6'd9) begin errors++; $display("FAIL single_cnt got=%0d exp=9", res_cnt); end
    checks++; if (acc[47:32] !== 16'd9) begin errors++; $display("FAIL single_acc2 got=%0d exp=9", acc[47:32]); end
    drive_cycle(1'b1, 4'b0000, rand_data(), 4'b0000);
    checks++; if (res_valid !== 1'b0 || res_id !== 2'd2 || res_cnt !== 6'd9) begin
      errors++; $display("FAIL single_hold got=%b/%0d/%0d exp=0/2/9", res_valid, res_id, res_cnt); end
  endtask

  task automatic test_round_robin();
    // Accept requester 3 with an empty word and clear everything: ptr -> 0.
    drive_cycle(1'b1, 4'b1000, 128'd0, 4'b1111);
    checks++; if (acc !== 64'd0) begin errors++; $display("FAIL rr_clear got=%h exp=0", acc); end
    for (int n = 0; n < 8; n++) begin
      drive_cycle(1'b1, 4'b1111, {128{1'b1}}, 4'b0000);
      checks++; if (obs_gnt !== 4'(1 << (n % 4))) begin
        errors++; $display("FAIL rr_gnt n=%0d got=%b exp=%b", n, obs_gnt, 4'(1 << (n % 4))); end
      checks++; if (res_id !== 2'(n % 4) || res_cnt !== 6'd32 || res_valid !== 1'b1) begin
        errors++; $display("FAIL rr_res n=%0d got=%b/%0d/%0d exp=1/%0d/32", n, res_valid, res_id, res_cnt, n % 4); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc[16*i +: 16] !== 16'd64) begin
        errors++; $display("FAIL rr_acc i=%0d got=%0d exp=64", i, acc[16*i +: 16]); end
    end
  endtask

  task automatic test_skip_wrap();
    drive_cycle(1'b1, 4'b0100, rand_data(), 4'b0000);   // ptr -> 3
    drive_cycle(1'b1, 4'b0110, rand_data(), 4'b0000);
    checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1 got=%b exp=0010", obs_gnt); end
    checks++; if (res_id !== 2'd1 || res_cnt !== 6'(m_rcnt)) begin
      errors++; $display("FAIL wrap_res1 got=%0d/%0d exp=1/%0d", res_id, res_cnt, m_rcnt); end
    drive_cycle(1'b1, 4'b0110, rand_data(), 4'b0000);
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL wrap_gnt2 got=%b exp=0100", obs_gnt); end
    checks++; if (res_id !== 2'd2 || res_cnt !== 6'(m_rcnt)) begin
      errors++; $display("FAIL wrap_res2 got=%0d/%0d exp=2/%0d", res_id, res_cnt, m_rcnt); end
  endtask

  task automatic test_saturation();
    logic [127:0] d;
    drive_cycle(1'b1, 4'b0000, 128'd0, 4'b0010);
    repeat (2047) drive_cycle(1'b1, 4'b0010, {128{1'b1}}, 4'b0000);   // 65504
    d = 128'd0; d[63:32] = 32'h0000_FFFF;
    drive_cycle(1'b1, 4'b0010, d, 4'b0000);
    checks++; if (acc[31:16] !== 16'hFFF0) begin errors++; $display("FAIL sat_preload got=%h exp=fff0", acc[31:16]); end
    drive_cycle(1'b1, 4'b0010, {128{1'b1}}, 4'b0000);
    checks++; if (acc[31:16] !== 16'hFFFF) begin errors++; $display("FAIL sat_top got=%h exp=ffff", acc[31:16]); end
    d = 128'd0; d[63:32] = 32'h0000_0001;
    drive_cycle(1'b1, 4'b0010, d, 4'b0000);
    checks++; if (acc[31:16] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", acc[31:16]); end
    checks++; if (res_cnt !== 6'd1 || res_valid !== 1'b1) begin
      errors++; $display("FAIL sat_res got=%b/%0d exp=1/1", res_valid, res_cnt); end
  endtask

  task automatic test_clear();
    logic [127:0] d;
    d = rand_data(); d[31:0] = 32'h0000_00FF;
    drive_cycle(1'b1, 4'b0001, d, 4'b0001);
    checks++; if (acc[15:0] !== 16'd8) begin errors++; $display("FAIL clr_collide got=%0d exp=8", acc[15:0]); end
    drive_cycle(1'b1, 4'b0000, rand_data(), 4'b0010);
    checks++; if (acc[31:16] !== 16'd0) begin errors++; $display("FAIL clr_alone got=%0d exp=0", acc[31:16]); end
    checks++; if (acc[15:0] !== 16'd8) begin errors++; $display("FAIL clr_other got=%0d exp=8", acc[15:0]); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", res_valid); end
  endtask

  task automatic test_random();
    logic [3:0]   pend;
    logic [31:0]  pw[4];
    logic [127:0] d;
    logic [3:0]   c;
    logic         rb;
    logic [7:0]   e;
    pend = '0;
    exp_q.delete();
    sb_on = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          case ($urandom_range(0, 3))
            0:       pw[i] = 32'h0;
            1:       pw[i] = 32'hFFFF_FFFF;
            default: pw[i] = $urandom();
          endcase
        end
      end
      d = {pw[3], pw[2], pw[1], pw[0]};
      for (int i = 0; i < 4; i++) c[i] = ($urandom_range(0, 15) == 0);
      rb = ($urandom_range(0, 39) != 0);
      drive_cycle(rb, pend, d, c);
      if (m_last_g >= 0) pend[m_last_g] = 1'b0;
      checks++; if (obs_gnt !== exp_gnt) begin
        errors++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, obs_gnt, exp_gnt); end
      checks++; if (res_valid !== m_rv) begin
        errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, res_valid, m_rv); end
      checks++; if (res_id !== 2'(m_rid) || res_cnt !== 6'(m_rcnt)) begin
        errors++; $display("FAIL rnd_res n=%0d got=%0d/%0d exp=%0d/%0d", n, res_id, res_cnt, m_rid, m_rcnt); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (acc[16*i +: 16] !== 16'(m_acc[i])) begin
          errors++; $display("FAIL rnd_acc n=%0d i=%0d got=%0d exp=%0d", n, i, acc[16*i +: 16], m_acc[i]); end
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_sb n=%0d got=%0d/%0d exp=none", n, res_id, res_cnt);
        end else begin
          e = exp_q.pop_front();
          if ({res_id, res_cnt} !== e) begin
            errors++; $display("FAIL rnd_sb n=%0d got=%0d/%0d exp=%0d/%0d", n, res_id, res_cnt, e[7:6], e[5:0]); end
        end
      end
    end
    sb_on = 1'b0;
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; req = '0; data = '0; clr = '0;
    model_reset();
    m_last_g = -1;
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_saturation();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/popcount_sched.md
# popcount_sched

Round-robin scheduler that shares one 32-bit population-count tree among four requesters. Each cycle it grants at most one pending request, drives the granted word through the tree, and returns a registered bit count tagged with the requester ID. It also maintains a per-requester saturating running total. It sits between the client blocks and the single bit-count datapath, so the tree is instantiated once instead of per client.

## Interface
- NREQ, 4: number of requesters; fixed at 4 in this revision, so IDs are 2 bits.
- ACC_W, 16: width of each per-requester running total.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  4  per-requester request; held high until granted.
- data  input  128  request words; requester i owns bits [32*i+31 : 32*i].
- clr  input  4  per-requester running-total clear, one-cycle pulse.
- gnt  output  4  one-hot grant, combinational from req and the priority pointer; all zero when req is all zero.
- res_valid  output  1  registered; high for one cycle per accepted request.
- res_id  output  2  registered; ID of the requester whose count is on res_cnt.
- res_cnt  output  6  registered; ones count of the accepted word, 0..32.
- acc  output  4*ACC_W  registered running totals; requester i owns bits [ACC_W*i+ACC_W-1 : ACC_W*i].

## Operation
- Request is accepted in the cycle where req[i] and gnt[i] are both high.
  - The requester must keep req[i] and its data word stable until that cycle.
  - The requester may drop req[i] only after the accepting edge.
- Arbitration uses a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first requester with req set in that order gets the grant.
- After an accept by requester g, ptr becomes g+1 (mod 4), wrapping 3 to 0.
  - With no accept, ptr holds.
- Granted word is muxed into one 32-input tree producing a 6-bit count.
  - The count equals the number of set bits: all ones gives 32, all zeros gives 0.
- On an accept:
  - res_valid is set to 1, res_id to g, res_cnt to the count.
  - acc[g] is increased by the count, zero-extended to ACC_W.
- Otherwise res_valid is 0; res_id and res_cnt hold their last values.
- Running totals saturate: if acc[g] + count exceeds 2^ACC_W-1, acc[g] becomes 2^ACC_W-1. They never wrap.
- clr[i] with no accept for requester i in the same cycle: acc[i] becomes 0 on the next edge.
- clr[i] together with an accept for requester i in the same cycle: clear applies first, so acc[i] becomes count.
- clr on channels other than g acts independently in the same cycle.
- No back-pressure on results: the consumer must take res_* in the cycle res_valid is high.

## Timing
- Arbitration and tree are combinational; everything else is a single register stage.
- Latency is 1 cycle from the accepting edge to res_valid, res_cnt and the updated acc.
- Throughput is one accept per cycle. With all four requesting continuously, each is granted exactly once every 4 cycles.
- Values after reset: ptr=0, res_valid=0, res_id=0, res_cnt=0, all acc=0.
- gnt during reset follows req with ptr=0, but no accept takes effect.
- Reset asserted mid-stream: on the next edge all state returns to reset values, and any result in flight is discarded.
- The first accept occurs in the first cycle where rst_n is sampled high.

## Test plan
- Reset behaviour: hold rst_n=0 for 3 cycles with req=4'b1111 -> res_valid=0, acc all 0. First accept after release goes to requester 0.
- Single requester: req=4'b0100 with data[95:64]=32'hF0F0_0001, held one cycle -> gnt=4'b0100. Next cycle res_valid=1, res_id=2, res_cnt=9, acc[2]=9.
- Round robin: req=4'b1111 for 8 cycles with all words 32'hFFFF_FFFF -> grant order 0,1,2,3,0,1,2,3. res_cnt=32 each cycle; every acc ends at 64.
- Skip and wrap: ptr=3 with req=4'b0110 -> gnt=4'b0010, then ptr=2. The next cycle with req=4'b0110 gives gnt=4'b0100.
- Saturation: preload acc[1] to 16'hFFF0 by repeated accepts, then accept 32'hFFFF_FFFF -> acc[1]=16'hFFFF. A further accept of 1 keeps 16'hFFFF.
- Clear collisions:
  - Accept of 32'h0000_00FF on requester 0 with clr=4'b0001 in the same cycle -> acc[0]=8.
  - clr=4'b0010 alone -> acc[1]=0 next cycle while acc[0] is unchanged.
